// File: rtl/alarma_zonas.sv
// Zoned alarm controller: exit/entry delays, timed horn, panic input and latched trigger zones.
// Define ALARMA_PULSO_EN to pulse the horn at a 2^PULSO_LOG2-cycle half-period instead of steady drive.
//
// state     | meaning
// DESARMADO | disarmed, sensors ignored
// SALIDA    | exit delay running, sensors ignored
// ARMADO    | armed, watching zones
// ENTRADA   | delayed zone tripped, entry delay running
// ALARMA    | horn active for T_BOCINA cycles
module alarma_zonas #(
   parameter int                  N_ZONAS      = 5,
   parameter int                  CNT_W        = 16,
   parameter int                  T_SALIDA     = 100,
   parameter int                  T_ENTRADA    = 50,
   parameter int                  T_BOCINA     = 200,
   parameter logic [N_ZONAS-1:0]  ZONA_RETARDO = 5'b00001,
   parameter int                  PULSO_LOG2   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               armar,
   input  logic [N_ZONAS-1:0] sensores,
   input  logic [N_ZONAS-1:0] mascara,
   input  logic               panico,
   output logic               bocina,
   output logic               armado,
   output logic [2:0]         estado,
   output logic [N_ZONAS-1:0] zona_disparo
);

   typedef enum logic [2:0] {
      DESARMADO = 3'd0,
      SALIDA    = 3'd1,
      ARMADO    = 3'd2,
      ENTRADA   = 3'd3,
      ALARMA    = 3'd4
   } estado_t;

   localparam logic [CNT_W-1:0] CARGA_SAL = CNT_W'(T_SALIDA - 1);
   localparam logic [CNT_W-1:0] CARGA_ENT = CNT_W'(T_ENTRADA - 1);
   localparam logic [CNT_W-1:0] CARGA_BOC = CNT_W'(T_BOCINA - 1);

   if (N_ZONAS < 1 || N_ZONAS > 16 || PULSO_LOG2 < 0) begin : g_cfg_invalida
      $error("alarma_zonas: invalid N_ZONAS or PULSO_LOG2");
   end

   estado_t            est;
   logic [CNT_W-1:0]   cnt;
   logic [N_ZONAS-1:0] zd;
   logic [N_ZONAS-1:0] pend;
   logic               armar_q;
   logic [N_ZONAS-1:0] activa, inst, ret;

   assign activa = sensores & ~mascara;
   assign inst   = activa & ~ZONA_RETARDO;
   assign ret    = activa & ZONA_RETARDO;

   // pend remembers the delayed zones seen during ENTRADA so an expiry can report them.
   // In ALARMA a disarm is a 1->0 change of armar, so a panic raised while disarmed sounds in full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         est     <= DESARMADO;
         cnt     <= '0;
         zd      <= '0;
         pend    <= '0;
         armar_q <= 1'b0;
      end else begin
         armar_q <= armar;
         pend    <= '0;
         case (est)
            DESARMADO: begin
               if (panico) begin
                  est <= ALARMA;
                  cnt <= CARGA_BOC;
               end else if (armar) begin
                  est <= SALIDA;
                  cnt <= CARGA_SAL;
               end
            end
            SALIDA: begin
               if (panico) begin
                  est <= ALARMA;
                  cnt <= CARGA_BOC;
               end else if (!armar) begin
                  est <= DESARMADO;
                  zd  <= '0;
               end else if (cnt == '0) begin
                  est <= ARMADO;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ARMADO: begin
               if (panico || (armar && inst != '0)) begin
                  est <= ALARMA;
                  cnt <= CARGA_BOC;
                  zd  <= zd | inst;
               end else if (!armar) begin
                  est <= DESARMADO;
                  zd  <= '0;
               end else if (ret != '0) begin
                  est  <= ENTRADA;
                  cnt  <= CARGA_ENT;
                  pend <= ret;
               end
            end
            ENTRADA: begin
               if (panico || (armar && (inst != '0 || cnt == '0))) begin
                  est <= ALARMA;
                  cnt <= CARGA_BOC;
                  zd  <= zd | inst | ret | pend;
               end else if (!armar) begin
                  est <= DESARMADO;
                  zd  <= '0;
               end else begin
                  cnt  <= cnt - 1'b1;
                  pend <= pend | ret;
               end
            end
            ALARMA: begin
               if (panico) begin
                  cnt <= CARGA_BOC;
               end else if (!armar && armar_q) begin
                  est <= DESARMADO;
                  zd  <= '0;
               end else if (cnt == '0) begin
                  if (armar) begin
                     est <= ARMADO;
                  end else begin
                     est <= DESARMADO;
                     zd  <= '0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               est <= DESARMADO;
               cnt <= '0;
               zd  <= '0;
            end
         endcase
      end
   end

   assign estado       = est;
   assign armado       = (est == ARMADO) || (est == ENTRADA);
   assign zona_disparo = zd;

`ifdef ALARMA_PULSO_EN
   logic [PULSO_LOG2:0] div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (est != ALARMA) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign bocina = (est == ALARMA) & ~div[PULSO_LOG2];
`else
   assign bocina = (est == ALARMA);
`endif

endmodule

// File: tb/tb_alarma_zonas.sv
// Self-checking bench for alarma_zonas: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alarma_zonas;
   localparam int         N   = 5;
   localparam int         TS  = 4;
   localparam int         TE  = 3;
   localparam int         TBO = 6;
   localparam int         PL  = 1;
   localparam logic [4:0] RET = 5'b00001;
`ifdef ALARMA_PULSO_EN
   localparam bit PULSO = 1'b1;
`else
   localparam bit PULSO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       armar = 1'b0;
   logic       panico = 1'b0;
   logic [4:0] sensores = '0;
   logic [4:0] mascara = '0;
   logic       bocina, armado;
   logic [2:0] estado;
   logic [4:0] zona_disparo;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   alarma_zonas #(
      .N_ZONAS(N), .CNT_W(16), .T_SALIDA(TS), .T_ENTRADA(TE), .T_BOCINA(TBO),
      .ZONA_RETARDO(RET), .PULSO_LOG2(PL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .armar(armar), .sensores(sensores), .mascara(mascara),
      .panico(panico), .bocina(bocina), .armado(armado), .estado(estado),
      .zona_disparo(zona_disparo)
   );

   function automatic void chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endfunction

   // Model: ms = mode (0 off, 1 leaving, 2 armed, 3 entry, 4 alarm), left = cycles still to spend
   // in the timed mode, since = cycles already spent sounding.
   int         ms, left, since;
   logic [4:0] mzd, mpend;
   bit         pa;

   task automatic model_step();
      logic [4:0] act, inst, ret, cause;
      bit trig;
      act   = sensores & ~mascara;
      inst  = act & ~RET;
      ret   = act & RET;
      trig  = 1'b0;
      cause = '0;
      case (ms)
         0: if (panico) trig = 1'b1;
            else if (armar) begin ms = 1; left = TS; end
         1: if (panico) trig = 1'b1;
            else if (!armar) ms = 0;
            else if (left == 1) ms = 2;
            else left--;
         2: begin
            cause = inst;
            if (panico) trig = 1'b1;
            else if (!armar) ms = 0;
            else if (inst != 0) trig = 1'b1;
            else if (ret != 0) begin ms = 3; left = TE; mpend = ret; end
         end
         3: begin
            cause = inst | ret | mpend;
            if (panico) trig = 1'b1;
            else if (!armar) ms = 0;
            else if (inst != 0 || left == 1) trig = 1'b1;
            else begin left--; mpend |= ret; end
         end
         default: begin
            since++;
            if (panico) left = TBO;
            else if (pa && !armar) ms = 0;
            else if (left == 1) ms = armar ? 2 : 0;
            else left--;
         end
      endcase
      if (trig) begin ms = 4; left = TBO; since = 0; mzd |= cause; end
      if (ms == 0) mzd = '0;
      pa = armar;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms = 0; left = 0; since = 0; mzd = '0; mpend = '0; pa = 1'b0;
      end else begin
         model_step();
      end
   end

   function automatic int exp_bocina();
      if (ms != 4) return 0;
      if (!PULSO) return 1;
      return ((since >> PL) & 1) == 0 ? 1 : 0;
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("estado", int'(estado), ms);
         chk("armado", int'(armado), (ms == 2 || ms == 3) ? 1 : 0);
         chk("bocina", int'(bocina), exp_bocina());
         chk("zona_disparo", int'(zona_disparo), int'(mzd));
      end
   end

   task automatic step(input logic a, input logic [4:0] s, input logic [4:0] m, input logic p);
      armar = a; sensores = s; mascara = m; panico = p;
      @(posedge clk);
      #1;
   endtask

   task automatic arm_up();
      for (int i = 0; i < TS + 1; i++) step(1'b1, 5'b0, 5'b0, 1'b0);
      chk("armed after exit delay", int'(estado), 2);
   endtask

   initial begin
      int exp_e[9];
      int pat[6];
      int n_on;
      exp_e = '{3, 3, 4, 4, 4, 4, 4, 4, 2};
      if (PULSO) pat = '{1, 1, 0, 0, 1, 1};
      else       pat = '{1, 1, 1, 1, 1, 1};

      #2;
      chk("reset estado", int'(estado), 0);
      chk("reset bocina", int'(bocina), 0);
      chk("reset armado", int'(armado), 0);
      chk("reset zona_disparo", int'(zona_disparo), 0);
      #10 rst_n = 1'b1;
      chk_on = 1'b1;

      // exit delay ignores open zones, then instant zones trigger
      for (int i = 0; i < TS; i++) begin
         step(1'b1, 5'b11111, 5'b0, 1'b0);
         chk("salida holds", int'(estado), 1);
      end
      step(1'b1, 5'b11111, 5'b0, 1'b0);
      chk("salida expiry", int'(estado), 2);
      step(1'b1, 5'b11111, 5'b0, 1'b0);
      chk("instant trigger", int'(estado), 4);
      chk("instant zones", int'(zona_disparo), 5'b11110);
      chk("horn first cycle", int'(bocina), 1);
      step(1'b0, 5'b0, 5'b0, 1'b0);
      chk("disarm from alarm", int'(estado), 0);
      chk("disarm clears zones", int'(zona_disparo), 0);

      // entry delay then timed horn, back to armed
      arm_up();
      step(1'b1, 5'b00001, 5'b0, 1'b0);
      chk("entry start", int'(estado), 3);
      n_on = 0;
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 5'b0, 5'b0, 1'b0);
         chk("entry/horn sequence", int'(estado), exp_e[i]);
         n_on += int'(bocina);
      end
      chk("horn cycles", n_on, PULSO ? 4 : 6);
      chk("entry zone latched", int'(zona_disparo), 5'b00001);
      step(1'b0, 5'b0, 5'b0, 1'b0);

      // disarm during entry delay
      arm_up();
      step(1'b1, 5'b00001, 5'b0, 1'b0);
      step(1'b1, 5'b0, 5'b0, 1'b0);
      step(1'b0, 5'b0, 5'b0, 1'b0);
      chk("entry disarm", int'(estado), 0);
      n_on = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 5'b0, 5'b0, 1'b0);
         n_on += int'(bocina);
      end
      chk("no horn after entry disarm", n_on, 0);
      chk("no zones after entry disarm", int'(zona_disparo), 0);

      // masked instant zone vs unmasked
      arm_up();
      step(1'b1, 5'b00101, 5'b00100, 1'b0);
      chk("masked instant -> entry", int'(estado), 3);
      step(1'b0, 5'b0, 5'b0, 1'b0);
      arm_up();
      step(1'b1, 5'b00101, 5'b0, 1'b0);
      chk("instant wins", int'(estado), 4);
      chk("instant wins zones", int'(zona_disparo), 5'b00100);
      step(1'b0, 5'b0, 5'b0, 1'b0);

      // panic while disarmed
      step(1'b0, 5'b0, 5'b0, 1'b1);
      chk("panic estado", int'(estado), 4);
      chk("panic horn 0", int'(bocina), pat[0]);
      for (int i = 1; i < 6; i++) begin
         step(1'b0, 5'b0, 5'b0, 1'b0);
         chk("panic horn pattern", int'(bocina), pat[i]);
      end
      step(1'b0, 5'b0, 5'b0, 1'b0);
      chk("panic ends disarmed", int'(estado), 0);
      chk("panic adds no zones", int'(zona_disparo), 0);

      // asynchronous reset while sounding
      step(1'b0, 5'b0, 5'b0, 1'b1);
      chk("pre-reset horn", int'(bocina), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset bocina", int'(bocina), 0);
      chk("async reset estado", int'(estado), 0);
      chk("async reset zones", int'(zona_disparo), 0);
      #1 rst_n = 1'b1;
      panico = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic a;
         a = armar;
         if ($urandom_range(0, 39) == 0) a = ~a;
         else if ($urandom_range(0, 199) == 0) a = 1'b1;
         step(a,
              ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0,
              ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0,
              $urandom_range(0, 59) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
